// File: rtl/ysyx_22050368_wbck.sv
// Write-back arbiter and output stage for the integer register file write port.
// Merges single-cycle ALU results and long-latency LSU results over valid/ready.
// A one-entry ALU skid buffer parks an ALU result that loses to the LSU.
// A starvation counter guarantees the buffer drains within two cycles of LSU traffic.
// Optional feature macro: YSYX_22050368_WBCK_FWD_EN adds combinational forwarding ports.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module ysyx_22050368_wbck #(
  parameter int unsigned XW = `XLEN,
  parameter int unsigned IW = `RFIDX_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_wbck_i_valid,
  output logic          alu_wbck_i_ready,
  input  logic          alu_wbck_i_wen,
  input  logic [IW-1:0] alu_wbck_i_idx,
  input  logic [XW-1:0] alu_wbck_i_dat,
  input  logic          lsu_wbck_i_valid,
  output logic          lsu_wbck_i_ready,
  input  logic          lsu_wbck_i_wen,
  input  logic [IW-1:0] lsu_wbck_i_idx,
  input  logic [XW-1:0] lsu_wbck_i_dat,
`ifdef YSYX_22050368_WBCK_FWD_EN
  input  logic [IW-1:0] fwd_rs1_idx,
  input  logic [IW-1:0] fwd_rs2_idx,
  output logic          fwd_rs1_hit,
  output logic          fwd_rs2_hit,
  output logic [XW-1:0] fwd_rs1_dat,
  output logic [XW-1:0] fwd_rs2_dat,
`endif
  output logic          wbck_dest_wen,
  output logic [IW-1:0] wbck_dest_idx,
  output logic [XW-1:0] wbck_dest_dat
);

  localparam int unsigned SCNT_W   = 2;
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(2);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e        buf_state, buf_state_nxt;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic              buf_load;

  logic              buf_wen;
  logic [IW-1:0]     buf_idx;
  logic [XW-1:0]     buf_dat;

  logic              buf_full;
  logic              starve;
  logic              alu_fire;
  logic              lsu_fire;
  logic              sel_buf;
  logic              sel_lsu;
  logic              sel_alu;

  logic              win_vld;
  logic              win_wen;
  logic [IW-1:0]     win_idx;
  logic [XW-1:0]     win_dat;

  // Readies depend only on state and reset, never on the valids
  assign buf_full         = (buf_state == FULL);
  assign starve           = buf_full && (scnt == SCNT_MAX);
  assign alu_wbck_i_ready = !rst && !buf_full;
  assign lsu_wbck_i_ready = !rst && !starve;

  assign alu_fire = alu_wbck_i_valid && alu_wbck_i_ready;
  assign lsu_fire = lsu_wbck_i_valid && lsu_wbck_i_ready;

  // Priority: starved buffer, then LSU, then buffer, then a fresh ALU result
  assign sel_buf = starve || (buf_full && !lsu_fire);
  assign sel_lsu = !starve && lsu_fire;
  assign sel_alu = !buf_full && !lsu_fire && alu_fire;

  // Winner payload mux
  always_comb begin
    win_vld = 1'b0;
    win_wen = 1'b0;
    win_idx = '0;
    win_dat = '0;
    if (sel_buf) begin
      win_vld = 1'b1;
      win_wen = buf_wen;
      win_idx = buf_idx;
      win_dat = buf_dat;
    end else if (sel_lsu) begin
      win_vld = 1'b1;
      win_wen = lsu_wbck_i_wen;
      win_idx = lsu_wbck_i_idx;
      win_dat = lsu_wbck_i_dat;
    end else if (sel_alu) begin
      win_vld = 1'b1;
      win_wen = alu_wbck_i_wen;
      win_idx = alu_wbck_i_idx;
      win_dat = alu_wbck_i_dat;
    end
  end

  // Skid buffer next state and starvation counter update
  always_comb begin
    buf_state_nxt = buf_state;
    scnt_nxt      = scnt;
    buf_load      = 1'b0;
    case (buf_state)
      EMPTY: begin
        scnt_nxt = '0;
        if (alu_fire && lsu_fire) begin
          buf_state_nxt = FULL;
          buf_load      = 1'b1;
        end
      end
      FULL: begin
        if (sel_buf) begin
          buf_state_nxt = EMPTY;
          scnt_nxt      = '0;
        end else if (sel_lsu && (scnt != SCNT_MAX)) begin
          scnt_nxt = scnt + SCNT_W'(1);
        end
      end
      default: begin
        buf_state_nxt = EMPTY;
        scnt_nxt      = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_state <= EMPTY;
      scnt      <= '0;
    end else begin
      buf_state <= buf_state_nxt;
      scnt      <= scnt_nxt;
    end
  end

  // Skid buffer payload capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wen <= 1'b0;
      buf_idx <= '0;
      buf_dat <= '0;
    end else if (buf_load) begin
      buf_wen <= alu_wbck_i_wen;
      buf_idx <= alu_wbck_i_idx;
      buf_dat <= alu_wbck_i_dat;
    end
  end

  // Registered regfile write port; writes to x0 are suppressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbck_dest_wen <= 1'b0;
      wbck_dest_idx <= '0;
      wbck_dest_dat <= '0;
    end else begin
      wbck_dest_wen <= win_vld && win_wen && (win_idx != IW'(0));
      if (win_vld) begin
        wbck_dest_idx <= win_idx;
        wbck_dest_dat <= win_dat;
      end
    end
  end

`ifdef YSYX_22050368_WBCK_FWD_EN
  // Same-cycle forwarding of the write being presented to the regfile
  assign fwd_rs1_hit = wbck_dest_wen && (wbck_dest_idx == fwd_rs1_idx);
  assign fwd_rs2_hit = wbck_dest_wen && (wbck_dest_idx == fwd_rs2_idx);
  assign fwd_rs1_dat = wbck_dest_dat;
  assign fwd_rs2_dat = wbck_dest_dat;
`endif

endmodule
